batrider_snd_cmd: RTL and testbench
===================================

// Module: batrider_snd_cmd
// PURPOSE
//  68000-side sound command port, directly upstream of batrider_sound. Latches 68k command bytes
//  into SOUNDLATCH/SOUNDLATCH2, pulses the sound block's CS (NMI edge) input, and holds 68k DTACK
//  until the Z80 clears the NMI (WAIT falls) or a timeout expires. Returns SOUNDLATCH3/4 to the 68k
//  and converts the Z80's SNDIRQ into a sticky, clearable 68k interrupt request.
// PARAMETERS
//  PULSE_W  2     SND_CS high time in cycles (>=2, so WAIT is high before the ack check starts)
//  TIMEOUT  4096  max cycles spent waiting for SND_WAIT low before forcing DTACK
// PORTS
//  CLK96         in   1  system clock (96 MHz domain)
//  RESET96_N     in   1  asynchronous active-low reset
//  M68K_CS       in   1  decoded sound-port select, held for the whole 68k bus cycle
//  M68K_RW       in   1  1=read, 0=write
//  M68K_LDS_N    in   1  lower data strobe, active low; only the low byte is used
//  M68K_A        in   2  register offset (word address bits 2:1)
//  M68K_DIN      in   8  68k write data, low byte
//  M68K_DOUT     out  8  read data
//  M68K_DTACK_N  out  1  bus acknowledge, active low
//  M68K_IRQ      out  1  sound-CPU interrupt request to 68k, level
//  SOUNDLATCH    out  8  command byte 0 to Z80
//  SOUNDLATCH2   out  8  command byte 1 to Z80
//  SND_CS        out  1  NMI trigger to batrider_sound (rising edge significant)
//  SND_WAIT      in   1  batrider_sound WAIT: high while Z80 NMI is pending
//  SND_IRQ       in   1  batrider_sound SNDIRQ
//  SOUNDLATCH3   in   8  Z80 reply byte 0
//  SOUNDLATCH4   in   8  Z80 reply byte 1
//  TIMEOUT_FLAG  out  1  sticky: at least one handshake timed out
// BEHAVIOUR
//  Reset: all outputs 0 except M68K_DTACK_N=1; FSM=IDLE; counters 0.
//  Register map: A=0 wr SOUNDLATCH+NMI; A=1 wr SOUNDLATCH2+NMI; A=2 rd SOUNDLATCH3, wr clears IRQ;
//   A=3 rd SOUNDLATCH4, wr ignored. Reads of A=0/1 return 8'hFF.
//  FSM states IDLE, PULSE, ACKWAIT, DONE:
//   IDLE: M68K_CS & RW -> M68K_DOUT registered at this edge, -> DONE (DTACK low 1 cycle after CS seen).
//    M68K_CS & !RW & !LDS_N & A<2 -> latch M68K_DIN, SND_CS<=1, pulse counter<=0, -> PULSE.
//    M68K_CS & !RW & (LDS_N | A>=2) -> apply A=2 IRQ clear if LDS_N low, -> DONE; no NMI.
//   PULSE: SND_CS high exactly PULSE_W cycles, then SND_CS<=0, timeout counter<=0, -> ACKWAIT.
//   ACKWAIT: SND_WAIT=0 -> DONE. Counter reaching TIMEOUT-1 -> TIMEOUT_FLAG<=1, -> DONE.
//   DONE: M68K_DTACK_N=0 while M68K_CS=1; M68K_CS=0 -> DTACK_N<=1, -> IDLE.
//  Write latency to DTACK: PULSE_W + ack cycles + 1; read latency 1 cycle.
//  M68K_CS dropping in PULSE/ACKWAIT (aborted cycle): pulse still completes full PULSE_W, ack wait
//   still runs; then DONE exits to IDLE next cycle with no DTACK asserted.
//  No new access is accepted outside IDLE; back-to-back cycles need CS low for >=1 cycle.
//  M68K_IRQ: set on SND_IRQ rising edge (1-cycle registered edge detect); cleared by A=2 write.
//   Simultaneous set and clear: set wins.
//  Latches are overwritten only by their own write; SOUNDLATCH3/4 sampled, not stored.
//  Timeout counter width $clog2(TIMEOUT); no wrap-around beyond TIMEOUT-1.
//  Reset asserted mid-transaction: immediate return to reset values, SND_CS drops at once.
// STRUCTURE
//  batrider_snd_pkg: register offset constants (REG_LATCH0..REG_REPLY1), FSM state enum.
//  Single module, no sub-modules; edge detector and counters inline.
// TESTING
//  1 Write A=0 0x5A, SND_WAIT rises 1 cycle after SND_CS, falls 20 cycles later -> SOUNDLATCH=0x5A,
//    SND_CS high 2 cycles, DTACK_N low on the cycle after WAIT falls, held until CS drops.
//  2 Write A=1 0x33, SND_WAIT held high -> DTACK_N low after 2+4096+1 cycles, TIMEOUT_FLAG=1 and
//    stays 1 through later successful writes.
//  3 Read A=2 with SOUNDLATCH3=0xC4 -> M68K_DOUT=0xC4, DTACK_N low 1 cycle after CS; read A=0 -> 0xFF.
//  4 SND_IRQ 0->1 -> M68K_IRQ=1; A=2 write -> 0; SND_IRQ edge coincident with A=2 write -> IRQ stays 1.
//  5 Write A=0 with LDS_N=1 -> DTACK given, SOUNDLATCH unchanged, SND_CS never rises.
//  6 Drop CS during PULSE, then assert RESET96_N=0 in ACKWAIT -> SND_CS=0, DTACK_N=1, FSM IDLE.

Source files
------------

// File: rtl/batrider_snd_pkg.sv
// Register offsets and handshake FSM states shared by the 68k sound command port.
package batrider_snd_pkg;

   localparam logic [1:0] REG_LATCH0 = 2'd0;
   localparam logic [1:0] REG_LATCH1 = 2'd1;
   localparam logic [1:0] REG_REPLY0 = 2'd2;
   localparam logic [1:0] REG_REPLY1 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_ACKWAIT = 2'd2,
      ST_DONE    = 2'd3
   } snd_state_t;

endpackage

// File: rtl/batrider_snd_cmd.sv
// 68k sound command port: latches command bytes, pulses SND_CS, holds DTACK until the Z80 clears its NMI.
// Latency: reads 1 cycle; writes PULSE_W + ack cycles + 1. The 68k bus is stalled via DTACK meanwhile.
module batrider_snd_cmd
   import batrider_snd_pkg::*;
#(
   parameter int PULSE_W = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic       CLK96,
   input  logic       RESET96_N,
   input  logic       M68K_CS,
   input  logic       M68K_RW,
   input  logic       M68K_LDS_N,
   input  logic [1:0] M68K_A,
   input  logic [7:0] M68K_DIN,
   output logic [7:0] M68K_DOUT,
   output logic       M68K_DTACK_N,
   output logic       M68K_IRQ,
   output logic [7:0] SOUNDLATCH,
   output logic [7:0] SOUNDLATCH2,
   output logic       SND_CS,
   input  logic       SND_WAIT,
   input  logic       SND_IRQ,
   input  logic [7:0] SOUNDLATCH3,
   input  logic [7:0] SOUNDLATCH4,
   output logic       TIMEOUT_FLAG
);

   localparam int PW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   snd_state_t    state, state_nxt;
   logic [PW-1:0] pcnt, pcnt_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic [7:0]    dout_nxt, latch0_nxt, latch1_nxt;
   logic          dtack_n_nxt, snd_cs_nxt, irq_nxt, tflag_nxt;
   logic          snd_irq_d, irq_clr;

   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         state        <= ST_IDLE;
         pcnt         <= '0;
         tcnt         <= '0;
         M68K_DOUT    <= 8'h00;
         M68K_DTACK_N <= 1'b1;
         M68K_IRQ     <= 1'b0;
         SOUNDLATCH   <= 8'h00;
         SOUNDLATCH2  <= 8'h00;
         SND_CS       <= 1'b0;
         TIMEOUT_FLAG <= 1'b0;
         snd_irq_d    <= 1'b0;
      end else begin
         state        <= state_nxt;
         pcnt         <= pcnt_nxt;
         tcnt         <= tcnt_nxt;
         M68K_DOUT    <= dout_nxt;
         M68K_DTACK_N <= dtack_n_nxt;
         M68K_IRQ     <= irq_nxt;
         SOUNDLATCH   <= latch0_nxt;
         SOUNDLATCH2  <= latch1_nxt;
         SND_CS       <= snd_cs_nxt;
         TIMEOUT_FLAG <= tflag_nxt;
         snd_irq_d    <= SND_IRQ;
      end
   end

   always_comb begin
      state_nxt   = state;
      pcnt_nxt    = pcnt;
      tcnt_nxt    = tcnt;
      dout_nxt    = M68K_DOUT;
      dtack_n_nxt = M68K_DTACK_N;
      latch0_nxt  = SOUNDLATCH;
      latch1_nxt  = SOUNDLATCH2;
      snd_cs_nxt  = SND_CS;
      tflag_nxt   = TIMEOUT_FLAG;
      irq_clr     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (M68K_CS) begin
               if (M68K_RW) begin
                  case (M68K_A)
                     REG_REPLY0: dout_nxt = SOUNDLATCH3;
                     REG_REPLY1: dout_nxt = SOUNDLATCH4;
                     default:    dout_nxt = 8'hFF;
                  endcase
                  dtack_n_nxt = 1'b0;
                  state_nxt   = ST_DONE;
               end else if (!M68K_LDS_N && !M68K_A[1]) begin
                  if (M68K_A == REG_LATCH0) latch0_nxt = M68K_DIN;
                  else                      latch1_nxt = M68K_DIN;
                  snd_cs_nxt = 1'b1;
                  pcnt_nxt   = '0;
                  state_nxt  = ST_PULSE;
               end else begin
                  irq_clr     = !M68K_LDS_N && (M68K_A == REG_REPLY0);
                  dtack_n_nxt = 1'b0;
                  state_nxt   = ST_DONE;
               end
            end
         end
         ST_PULSE: begin
            if (pcnt == PW'(PULSE_W - 1)) begin
               snd_cs_nxt = 1'b0;
               tcnt_nxt   = '0;
               state_nxt  = ST_ACKWAIT;
            end else begin
               pcnt_nxt = pcnt + PW'(1);
            end
         end
         ST_ACKWAIT: begin
            // An aborted bus cycle still finishes the handshake, but DTACK stays off.
            if (!SND_WAIT) begin
               dtack_n_nxt = !M68K_CS;
               state_nxt   = ST_DONE;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               tflag_nxt   = 1'b1;
               dtack_n_nxt = !M68K_CS;
               state_nxt   = ST_DONE;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
            end
         end
         ST_DONE: begin
            if (!M68K_CS) begin
               dtack_n_nxt = 1'b1;
               state_nxt   = ST_IDLE;
            end else begin
               dtack_n_nxt = 1'b0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A new SND_IRQ edge outranks a coincident clear.
      irq_nxt = M68K_IRQ;
      if (irq_clr)                irq_nxt = 1'b0;
      if (SND_IRQ && !snd_irq_d)  irq_nxt = 1'b1;
   end

endmodule

// File: tb/tb_batrider_snd_cmd.sv
// Directed bench for batrider_snd_cmd: write/read handshakes, timeout, IRQ set/clear, abort and reset.
module tb_batrider_snd_cmd;
   import batrider_snd_pkg::*;

   logic       CLK96 = 1'b0;
   logic       RESET96_N;
   logic       M68K_CS, M68K_RW, M68K_LDS_N;
   logic [1:0] M68K_A;
   logic [7:0] M68K_DIN, M68K_DOUT;
   logic       M68K_DTACK_N, M68K_IRQ;
   logic [7:0] SOUNDLATCH, SOUNDLATCH2, SOUNDLATCH3, SOUNDLATCH4;
   logic       SND_CS, SND_WAIT, SND_IRQ, TIMEOUT_FLAG;

   int vectors = 0;
   int miscompares = 0;
   int cnt;

   batrider_snd_cmd #(.PULSE_W(2), .TIMEOUT(4096)) dut (
      .CLK96(CLK96), .RESET96_N(RESET96_N),
      .M68K_CS(M68K_CS), .M68K_RW(M68K_RW), .M68K_LDS_N(M68K_LDS_N),
      .M68K_A(M68K_A), .M68K_DIN(M68K_DIN), .M68K_DOUT(M68K_DOUT),
      .M68K_DTACK_N(M68K_DTACK_N), .M68K_IRQ(M68K_IRQ),
      .SOUNDLATCH(SOUNDLATCH), .SOUNDLATCH2(SOUNDLATCH2),
      .SND_CS(SND_CS), .SND_WAIT(SND_WAIT), .SND_IRQ(SND_IRQ),
      .SOUNDLATCH3(SOUNDLATCH3), .SOUNDLATCH4(SOUNDLATCH4),
      .TIMEOUT_FLAG(TIMEOUT_FLAG)
   );

   always #5 CLK96 = ~CLK96;

   task automatic tick();
      @(posedge CLK96);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic cs, input logic rw, input logic lds_n,
                      input logic [1:0] a, input logic [7:0] din);
      M68K_CS = cs; M68K_RW = rw; M68K_LDS_N = lds_n; M68K_A = a; M68K_DIN = din;
   endtask

   initial begin
      RESET96_N = 1'b0;
      bus(1'b0, 1'b1, 1'b1, 2'd0, 8'h00);
      SND_WAIT = 1'b0; SND_IRQ = 1'b0; SOUNDLATCH3 = 8'h00; SOUNDLATCH4 = 8'h00;
      repeat (3) tick();
      chk("rst_dtack_n", 16'(M68K_DTACK_N), 16'd1);
      chk("rst_snd_cs",  16'(SND_CS), 16'd0);
      chk("rst_latch0",  16'(SOUNDLATCH), 16'h00);
      chk("rst_irq",     16'(M68K_IRQ), 16'd0);
      chk("rst_tflag",   16'(TIMEOUT_FLAG), 16'd0);
      chk("rst_dout",    16'(M68K_DOUT), 16'h00);
      RESET96_N = 1'b1;
      tick();

      // 1: write A=0, WAIT high 1 cycle after SND_CS for 20 cycles
      bus(1'b1, 1'b0, 1'b0, 2'd0, 8'h5A);
      tick();
      chk("t1_cs_rise",  16'(SND_CS), 16'd1);
      chk("t1_latch0",   16'(SOUNDLATCH), 16'h5A);
      SND_WAIT = 1'b1;
      tick();
      chk("t1_cs_hi2",   16'(SND_CS), 16'd1);
      tick();
      chk("t1_cs_fall",  16'(SND_CS), 16'd0);
      repeat (18) tick();
      chk("t1_dtack_wait", 16'(M68K_DTACK_N), 16'd1);
      SND_WAIT = 1'b0;
      tick();
      chk("t1_dtack_lo", 16'(M68K_DTACK_N), 16'd0);
      repeat (2) tick();
      chk("t1_dtack_hold", 16'(M68K_DTACK_N), 16'd0);
      M68K_CS = 1'b0;
      tick();
      chk("t1_dtack_rel", 16'(M68K_DTACK_N), 16'd1);
      chk("t1_latch1_kept", 16'(SOUNDLATCH2), 16'h00);

      // 2: write A=1 with WAIT stuck high -> timeout
      SND_WAIT = 1'b1;
      bus(1'b1, 1'b0, 1'b0, 2'd1, 8'h33);
      cnt = 0;
      do begin tick(); cnt++; end while (M68K_DTACK_N && cnt < 5000);
      chk("t2_latency", 16'(cnt), 16'd4099);
      chk("t2_tflag",   16'(TIMEOUT_FLAG), 16'd1);
      chk("t2_latch1",  16'(SOUNDLATCH2), 16'h33);
      chk("t2_latch0_kept", 16'(SOUNDLATCH), 16'h5A);
      M68K_CS = 1'b0; SND_WAIT = 1'b0;
      tick();
      bus(1'b1, 1'b0, 1'b0, 2'd0, 8'hA5);
      cnt = 0;
      do begin tick(); cnt++; end while (M68K_DTACK_N && cnt < 50);
      chk("t2_fast_latency", 16'(cnt), 16'd4);
      chk("t2_tflag_sticky", 16'(TIMEOUT_FLAG), 16'd1);
      chk("t2_latch0_new",   16'(SOUNDLATCH), 16'hA5);
      M68K_CS = 1'b0;
      tick();

      // 3: reads
      SOUNDLATCH3 = 8'hC4; SOUNDLATCH4 = 8'h7E;
      bus(1'b1, 1'b1, 1'b0, 2'd2, 8'h00);
      tick();
      chk("t3_rd2_dout",  16'(M68K_DOUT), 16'hC4);
      chk("t3_rd2_dtack", 16'(M68K_DTACK_N), 16'd0);
      M68K_CS = 1'b0;
      tick();
      bus(1'b1, 1'b1, 1'b0, 2'd3, 8'h00);
      tick();
      chk("t3_rd3_dout",  16'(M68K_DOUT), 16'h7E);
      M68K_CS = 1'b0;
      tick();
      bus(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
      tick();
      chk("t3_rd0_dout",  16'(M68K_DOUT), 16'hFF);
      chk("t3_rd_no_nmi", 16'(SND_CS), 16'd0);
      M68K_CS = 1'b0;
      tick();

      // 4: IRQ set, clear, and set-wins-over-clear
      SND_IRQ = 1'b1;
      tick();
      chk("t4_irq_set", 16'(M68K_IRQ), 16'd1);
      SND_IRQ = 1'b0;
      tick();
      chk("t4_irq_sticky", 16'(M68K_IRQ), 16'd1);
      bus(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
      tick();
      chk("t4_irq_clr",    16'(M68K_IRQ), 16'd0);
      chk("t4_clr_dtack",  16'(M68K_DTACK_N), 16'd0);
      chk("t4_clr_no_nmi", 16'(SND_CS), 16'd0);
      M68K_CS = 1'b0;
      tick();
      bus(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
      SND_IRQ = 1'b1;
      tick();
      chk("t4_set_wins", 16'(M68K_IRQ), 16'd1);
      M68K_CS = 1'b0; SND_IRQ = 1'b0;
      tick();

      // 5: write with LDS_N high
      bus(1'b1, 1'b0, 1'b1, 2'd0, 8'h11);
      tick();
      chk("t5_dtack",  16'(M68K_DTACK_N), 16'd0);
      chk("t5_no_nmi", 16'(SND_CS), 16'd0);
      chk("t5_latch0", 16'(SOUNDLATCH), 16'hA5);
      M68K_CS = 1'b0;
      tick();

      // 6a: abort during PULSE without reset -> handshake runs, no DTACK
      bus(1'b1, 1'b0, 1'b0, 2'd0, 8'h22);
      tick();
      M68K_CS = 1'b0;
      tick();
      chk("t6a_pulse_cont", 16'(SND_CS), 16'd1);
      cnt = 0;
      repeat (4) begin tick(); if (!M68K_DTACK_N) cnt++; end
      chk("t6a_no_dtack", 16'(cnt), 16'd0);
      chk("t6a_idle", 16'(dut.state), 16'(ST_IDLE));

      // 6b: abort during PULSE, reset while in ACKWAIT
      SND_WAIT = 1'b1;
      bus(1'b1, 1'b0, 1'b0, 2'd1, 8'h99);
      tick();
      M68K_CS = 1'b0;
      repeat (3) tick();
      chk("t6b_ackwait", 16'(dut.state), 16'(ST_ACKWAIT));
      RESET96_N = 1'b0;
      #1;
      chk("t6b_rst_cs",    16'(SND_CS), 16'd0);
      chk("t6b_rst_dtack", 16'(M68K_DTACK_N), 16'd1);
      chk("t6b_rst_idle",  16'(dut.state), 16'(ST_IDLE));
      chk("t6b_rst_latch", 16'(SOUNDLATCH2), 16'h00);
      chk("t6b_rst_tflag", 16'(TIMEOUT_FLAG), 16'd0);
      tick();
      RESET96_N = 1'b1; SND_WAIT = 1'b0;
      tick();

      // 6c: reset while SND_CS is high drops it at once
      bus(1'b1, 1'b0, 1'b0, 2'd0, 8'h44);
      tick();
      chk("t6c_cs_hi", 16'(SND_CS), 16'd1);
      #2 RESET96_N = 1'b0;
      #1;
      chk("t6c_cs_drop", 16'(SND_CS), 16'd0);
      M68K_CS = 1'b0;
      tick();
      RESET96_N = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
